// File: rtl/banks_pea_sel_sequencer_pkg.sv
// rtl/banks_pea_sel_sequencer_pkg.sv - shared crossbar selector definitions
package xbar_pkg;

   localparam int DEF_N_PE_PER_GROUP     = 4;
   localparam int DEF_N_BANKS_PER_STREAM = 4;
   localparam int DEF_N_STEPS            = 8;
   localparam int DEF_CNT_W              = 16;

   localparam int LOG_N_BANKS_PER_STREAM = $clog2(DEF_N_BANKS_PER_STREAM);
   localparam int LOG_N_PE_PER_GROUP     = $clog2(DEF_N_PE_PER_GROUP);

   localparam int SEL_DP_W = DEF_N_PE_PER_GROUP * LOG_N_BANKS_PER_STREAM;
   localparam int SEL_PD_W = DEF_N_BANKS_PER_STREAM * LOG_N_PE_PER_GROUP;

   // One table entry: both selector vectors, dmem->pea in the upper bits
   typedef struct packed {
      logic [SEL_DP_W-1:0] dmem_pea;
      logic [SEL_PD_W-1:0] pea_dmem;
   } sel_entry_t;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } sel_seq_state_e;

endpackage

// File: rtl/banks_pea_sel_sequencer_if.sv
// rtl/banks_pea_sel_sequencer_if.sv - config, run handshake and selector bundle
interface banks_pea_sel_sequencer_if #(
   parameter int N_PE_PER_GROUP     = 4,
   parameter int N_BANKS_PER_STREAM = 4,
   parameter int N_STEPS            = 8,
   parameter int CNT_W              = 16
);
   localparam int STEP_W = $clog2(N_STEPS);
   localparam int DP_W   = N_PE_PER_GROUP * $clog2(N_BANKS_PER_STREAM);
   localparam int PD_W   = N_BANKS_PER_STREAM * $clog2(N_PE_PER_GROUP);

   logic              cfg_we_i;
   logic [STEP_W-1:0] cfg_addr_i;
   logic [DP_W-1:0]   cfg_sel_dmem_pea_i;
   logic [PD_W-1:0]   cfg_sel_pea_dmem_i;
   logic [STEP_W:0]   cfg_len_i;
   logic [CNT_W-1:0]  cfg_iter_i;
   logic              start_i;
   logic              stall_i;
   logic              busy_o;
   logic              valid_o;
   logic [DP_W-1:0]   sel_dmem_pea_o;
   logic [PD_W-1:0]   sel_pea_dmem_o;
   logic              done_o;

   modport master (
      output cfg_we_i, cfg_addr_i, cfg_sel_dmem_pea_i, cfg_sel_pea_dmem_i,
             cfg_len_i, cfg_iter_i, start_i, stall_i,
      input  busy_o, valid_o, sel_dmem_pea_o, sel_pea_dmem_o, done_o
   );

   modport slave (
      input  cfg_we_i, cfg_addr_i, cfg_sel_dmem_pea_i, cfg_sel_pea_dmem_i,
             cfg_len_i, cfg_iter_i, start_i, stall_i,
      output busy_o, valid_o, sel_dmem_pea_o, sel_pea_dmem_o, done_o
   );

endinterface

// File: rtl/banks_pea_sel_sequencer_table.sv
// rtl/banks_pea_sel_sequencer_table.sv - selector pattern table, one write port, async read
module sel_pattern_table #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 16,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [ENTRY_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [ENTRY_W-1:0] rdata_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   // Reset clears every entry; otherwise a single write per cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/banks_pea_sel_sequencer.sv
// rtl/banks_pea_sel_sequencer.sv - replays a selector table len x iter times per run
module banks_pea_sel_sequencer
   import xbar_pkg::*;
#(
   parameter int N_PE_PER_GROUP     = DEF_N_PE_PER_GROUP,
   parameter int N_BANKS_PER_STREAM = DEF_N_BANKS_PER_STREAM,
   parameter int N_STEPS            = DEF_N_STEPS,
   parameter int CNT_W              = DEF_CNT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   banks_pea_sel_sequencer_if.slave bus
);

   localparam int STEP_W  = $clog2(N_STEPS);
   localparam int LEN_W   = STEP_W + 1;
   localparam int DP_W    = N_PE_PER_GROUP * $clog2(N_BANKS_PER_STREAM);
   localparam int PD_W    = N_BANKS_PER_STREAM * $clog2(N_PE_PER_GROUP);
   localparam int ENTRY_W = DP_W + PD_W;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_STEPS);

   sel_seq_state_e     state_q;
   logic [STEP_W-1:0]  step_q;
   logic [STEP_W-1:0]  last_step_q;
   logic [CNT_W-1:0]   iter_q;
   logic [CNT_W-1:0]   iter_last_q;
   logic               busy_q;
   logic               valid_q;
   logic               done_q;
   logic [DP_W-1:0]    sel_dp_q;
   logic [PD_W-1:0]    sel_pd_q;

   logic [LEN_W-1:0]   len_d;
   logic               tbl_we;
   logic [ENTRY_W-1:0] rd_entry;

   // Table is only writable while idle; zero or oversize lengths mean a full table
   always_comb begin
      tbl_we = bus.cfg_we_i && (state_q == SEQ_IDLE);
      len_d  = bus.cfg_len_i;
      if (bus.cfg_len_i == '0 || bus.cfg_len_i > LEN_MAX) begin
         len_d = LEN_MAX;
      end
   end

   sel_pattern_table #(
      .DEPTH   (N_STEPS),
      .ENTRY_W (ENTRY_W)
   ) u_table (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (tbl_we),
      .waddr_i (bus.cfg_addr_i),
      .wdata_i ({bus.cfg_sel_dmem_pea_i, bus.cfg_sel_pea_dmem_i}),
      .raddr_i (step_q),
      .rdata_o (rd_entry)
   );

   // Run FSM: step/iteration counters and all registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= SEQ_IDLE;
         step_q      <= '0;
         last_step_q <= '0;
         iter_q      <= '0;
         iter_last_q <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         sel_dp_q    <= '0;
         sel_pd_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            SEQ_IDLE: begin
               if (bus.start_i) begin
                  step_q      <= '0;
                  iter_q      <= '0;
                  last_step_q <= STEP_W'(len_d - LEN_W'(1));
                  iter_last_q <= bus.cfg_iter_i - CNT_W'(1);
                  busy_q      <= 1'b1;
                  state_q     <= (bus.cfg_iter_i == '0) ? SEQ_DONE : SEQ_RUN;
               end
            end
            SEQ_RUN: begin
               if (!bus.stall_i) begin
                  sel_dp_q <= rd_entry[ENTRY_W-1 -: DP_W];
                  sel_pd_q <= rd_entry[PD_W-1:0];
                  valid_q  <= 1'b1;
                  if (step_q == last_step_q) begin
                     step_q <= '0;
                     iter_q <= iter_q + CNT_W'(1);
                     // iter_last_q is iter-1, so the compare never needs iter_q to reach 2^CNT_W
                     if (iter_q == iter_last_q) begin
                        state_q <= SEQ_DONE;
                     end
                  end else begin
                     step_q <= step_q + STEP_W'(1);
                  end
               end
            end
            SEQ_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= SEQ_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= SEQ_IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o         = busy_q;
   assign bus.valid_o        = valid_q;
   assign bus.done_o         = done_q;
   assign bus.sel_dmem_pea_o = sel_dp_q;
   assign bus.sel_pea_dmem_o = sel_pd_q;

endmodule

// File: tb/tb_banks_pea_sel_sequencer.sv
// tb/tb_banks_pea_sel_sequencer.sv - scoreboard bench for the selector sequencer
`timescale 1ns/1ps
module tb_banks_pea_sel_sequencer;
   import xbar_pkg::*;

   localparam int NPE = 4;
   localparam int NB  = 4;
   localparam int NS  = 8;
   localparam int CW  = 12;

   typedef struct {
      sel_entry_t e;
      int         c;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   sel_entry_t model_tbl [NS];
   sel_entry_t last_sel;
   beat_t      beat_q [$];
   int         done_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   banks_pea_sel_sequencer_if #(
      .N_PE_PER_GROUP(NPE), .N_BANKS_PER_STREAM(NB), .N_STEPS(NS), .CNT_W(CW)
   ) bus ();

   banks_pea_sel_sequencer #(
      .N_PE_PER_GROUP(NPE), .N_BANKS_PER_STREAM(NB), .N_STEPS(NS), .CNT_W(CW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a beat or a done pulse
   always @(negedge clk) begin
      sel_entry_t cur;
      beat_t      b;
      if (!rst) begin
         cur.dmem_pea = bus.sel_dmem_pea_o;
         cur.pea_dmem = bus.sel_pea_dmem_o;
         if (bus.valid_o) begin
            if (beat_q.size() == 0) begin
               flag("unexpected_beat");
            end else begin
               b = beat_q.pop_front();
               check("beat_sel", 64'(cur), 64'(b.e));
               check("beat_cycle", 64'(cyc), 64'(b.c));
            end
            last_sel = cur;
         end else begin
            check("sel_hold", 64'(cur), 64'(last_sel));
         end
         if (bus.done_o) begin
            done_cnt++;
            if (done_q.size() == 0) flag("unexpected_done");
            else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
         end
      end
   end

   // Reference: beats walk the table len entries per iteration; a stall in cycle c delays the beat of c+1
   function automatic int push_expect(input int t, input int len, input int iter, input logic [63:0] mask);
      int leff;
      int c;
      leff = (len == 0 || len > NS) ? NS : len;
      c = t + 1;
      for (int it = 0; it < iter; it++) begin
         for (int s = 0; s < leff; s++) begin
            while ((c - 1 - t) < 64 && mask[c - 1 - t]) c++;
            beat_q.push_back('{e: model_tbl[s], c: c});
            c++;
         end
      end
      done_q.push_back(c);
      return c;
   endfunction

   task automatic write_entry(input int addr, input sel_entry_t e);
      @(posedge clk); #1;
      bus.cfg_we_i           = 1'b1;
      bus.cfg_addr_i         = 3'(addr);
      bus.cfg_sel_dmem_pea_i = e.dmem_pea;
      bus.cfg_sel_pea_dmem_i = e.pea_dmem;
      model_tbl[addr]        = e;
      @(posedge clk); #1;
      bus.cfg_we_i = 1'b0;
   endtask

   // One run; optional same-cycle write with start, optional ignored write+start at cycle t+inj
   task automatic run(input int len, input int iter, input logic [63:0] mask,
                      input bit wr, input int waddr, input sel_entry_t we_e, input int inj);
      int t;
      int dc;
      int j;
      int done_before;
      @(posedge clk); #1;
      bus.cfg_len_i  = 4'(len);
      bus.cfg_iter_i = CW'(iter);
      bus.start_i    = 1'b1;
      if (wr) begin
         bus.cfg_we_i           = 1'b1;
         bus.cfg_addr_i         = 3'(waddr);
         bus.cfg_sel_dmem_pea_i = we_e.dmem_pea;
         bus.cfg_sel_pea_dmem_i = we_e.pea_dmem;
         model_tbl[waddr]       = we_e;
      end
      t = cyc + 1;
      dc = push_expect(t, len, iter, mask);
      done_before = done_cnt;
      j = 0;
      while (cyc < dc + 1) begin
         @(posedge clk); #1;
         bus.start_i  = 1'b0;
         bus.cfg_we_i = 1'b0;
         bus.stall_i  = (j < 64) ? mask[j] : 1'b0;
         if (j == inj) begin
            bus.cfg_we_i           = 1'b1;
            bus.cfg_addr_i         = 3'd0;
            bus.cfg_sel_dmem_pea_i = ~model_tbl[0].dmem_pea;
            bus.cfg_sel_pea_dmem_i = ~model_tbl[0].pea_dmem;
            bus.start_i            = 1'b1;
         end
         j++;
      end
      bus.stall_i  = 1'b0;
      bus.start_i  = 1'b0;
      bus.cfg_we_i = 1'b0;
      check("busy_after_done", 64'(bus.busy_o), 64'(0));
      check("done_count", 64'(done_cnt - done_before), 64'(1));
      if (beat_q.size() != 0 || done_q.size() != 0) begin
         flag("missing_beats_or_done");
         beat_q.delete();
         done_q.delete();
      end
   endtask

   initial begin
      sel_entry_t e;
      sel_entry_t none;
      int         t;
      none = '0;
      last_sel = '0;
      for (int i = 0; i < NS; i++) model_tbl[i] = '0;
      bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_sel_dmem_pea_i = '0;
      bus.cfg_sel_pea_dmem_i = '0; bus.cfg_len_i = '0; bus.cfg_iter_i = '0;
      bus.start_i = 1'b0; bus.stall_i = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy_o), 64'(0));
      check("rst_valid", 64'(bus.valid_o), 64'(0));
      check("rst_done", 64'(bus.done_o), 64'(0));
      check("rst_sel_dp", 64'(bus.sel_dmem_pea_o), 64'(0));
      check("rst_sel_pd", 64'(bus.sel_pea_dmem_o), 64'(0));
      rst = 1'b0;

      // Distinct entries 0..3, len=4 iter=2
      for (int i = 0; i < 4; i++) begin
         e.dmem_pea = 8'(8'h11 * (i + 1));
         e.pea_dmem = 8'(8'hA0 + i);
         write_entry(i, e);
      end
      run(4, 2, 64'h0, 1'b0, 0, none, -1);
      // Stalls in cycles t+1 and t+2
      run(3, 1, 64'h6, 1'b0, 0, none, -1);
      // Zero iterations, then zero length meaning full table
      run(4, 0, 64'h0, 1'b0, 0, none, -1);
      run(0, 1, 64'h0, 1'b0, 0, none, -1);
      // Write and start mid-run are ignored; entry 0 keeps its value afterwards
      run(8, 1, 64'h0, 1'b0, 0, none, 3);
      run(1, 1, 64'h0, 1'b0, 0, none, -1);
      // Write landing in the same cycle as start
      e.dmem_pea = 8'h5C; e.pea_dmem = 8'hC5;
      run(2, 2, 64'h0, 1'b1, 0, e, -1);

      // Randomized runs
      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < 2; k++) begin
            e = sel_entry_t'($urandom_range(0, 65535));
            write_entry($urandom_range(0, NS - 1), e);
         end
         e = sel_entry_t'($urandom_range(0, 65535));
         run($urandom_range(0, 15), $urandom_range(0, 3),
             {$urandom, $urandom} & {$urandom, $urandom},
             1'($urandom_range(0, 1)), $urandom_range(0, NS - 1), e, -1);
      end

      // Reset on the 3rd beat of a len=8 iter=4 run
      @(posedge clk); #1;
      bus.cfg_len_i = 4'd8; bus.cfg_iter_i = CW'(4); bus.start_i = 1'b1;
      t = cyc + 1;
      void'(push_expect(t, 8, 4, 64'h0));
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      while (cyc < t + 3) begin
         @(posedge clk);
      end
      #2;
      rst = 1'b1;
      #1;
      check("abort_valid", 64'(bus.valid_o), 64'(0));
      check("abort_busy", 64'(bus.busy_o), 64'(0));
      check("abort_done", 64'(bus.done_o), 64'(0));
      check("abort_sel", 64'({bus.sel_dmem_pea_o, bus.sel_pea_dmem_o}), 64'(0));
      beat_q.delete();
      done_q.delete();
      last_sel = '0;
      for (int i = 0; i < NS; i++) model_tbl[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      run(8, 1, 64'h0, 1'b0, 0, none, -1);
      e.dmem_pea = 8'h3C; e.pea_dmem = 8'h96;
      write_entry(5, e);
      run(6, 2, 64'h0, 1'b0, 0, none, -1);

      // Maximum iteration count with a full table
      for (int i = 0; i < NS; i++) begin
         e = sel_entry_t'($urandom_range(0, 65535));
         write_entry(i, e);
      end
      run(NS, (1 << CW) - 1, 64'h0, 1'b0, 0, none, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
